// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair.
// Optional MULDIV_EARLY_OUT_EN: multiplies leave RUN once multiplier bits run out.
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt;
   logic               div_q;
   logic               neg_a;
   logic               neg_b;
   logic               dz;
   logic [WIDTH-1:0]   a;
   logic [2*WIDTH-1:0] b;
   logic [2*WIDTH-1:0] p;

   logic               sgn;
   logic               rt_zero;
   logic [WIDTH-1:0]   rs_mag;
   logic [WIDTH-1:0]   rt_mag;
   logic [WIDTH:0]     trial;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic               early;
   logic               last;

   assign sgn     = ~op[0];
   assign rt_zero = (rt_val == '0);
   assign rs_mag  = (sgn && rs_val[WIDTH-1]) ? -rs_val : rs_val;
   assign rt_mag  = (sgn && rt_val[WIDTH-1]) ? -rt_val : rt_val;

   // a: multiplier (mult) or dividend/quotient shifter (div)
   // b: shifting multiplicand (mult) or divisor in low half (div)
   // p: product accumulator (mult) or partial remainder in low half (div)
   assign trial = {p[WIDTH-1:0], a[WIDTH-1]}
                - {1'b0, b[WIDTH-1:0]};
   assign prod  = (neg_a ^ neg_b) ? -p : p;
   assign quo   = (neg_a ^ neg_b) ? -a : a;
   assign rem   = neg_a ? -p[WIDTH-1:0] : p[WIDTH-1:0];

`ifdef MULDIV_EARLY_OUT_EN
   assign early = ~div_q && (a[WIDTH-1:1] == '0);
`else
   assign early = 1'b0;
`endif

   assign last = (cnt == CNT_W'(WIDTH-1)) || early;
   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (start)
               state_n = (op[1] && rt_zero) ? FIX : RUN;
         end
         RUN: begin
            if (last) state_n = FIX;
         end
         FIX:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         div_q    <= 1'b0;
         neg_a    <= 1'b0;
         neg_b    <= 1'b0;
         dz       <= 1'b0;
         a        <= '0;
         b        <= '0;
         p        <= '0;
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         unique case (state)
            IDLE: begin
               if (hi_we) hi <= wdata;
               if (lo_we) lo <= wdata;
               if (start) begin
                  cnt   <= '0;
                  div_q <= op[1];
                  neg_a <= sgn & rs_val[WIDTH-1];
                  neg_b <= sgn & rt_val[WIDTH-1];
                  dz    <= op[1] & rt_zero;
                  a     <= op[1] ? rs_mag : rt_mag;
                  b     <= {{WIDTH{1'b0}},
                            (op[1] ? rt_mag : rs_mag)};
                  p     <= '0;
               end
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               if (div_q) begin
                  if (!trial[WIDTH]) begin
                     p[WIDTH-1:0] <= trial[WIDTH-1:0];
                     a <= {a[WIDTH-2:0], 1'b1};
                  end else begin
                     p[WIDTH-1:0] <= {p[WIDTH-2:0], a[WIDTH-1]};
                     a <= {a[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  if (a[0]) p <= p + b;
                  b <= b << 1;
                  a <= a >> 1;
               end
            end
            FIX: begin
               done     <= 1'b1;
               div_zero <= dz;
               if (!dz) begin
                  if (div_q) begin
                     hi <= rem;
                     lo <= quo;
                  end else begin
                     hi <= prod[2*WIDTH-1:WIDTH];
                     lo <= prod[WIDTH-1:0];
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit.
// Expected latency follows MULDIV_EARLY_OUT_EN when defined.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t0    = 0;

   logic [31:0] sh_hi = '0;
   logic [31:0] sh_lo = '0;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          lat;
   } exp_t;

   typedef struct {
      logic [1:0]  o;
      logic [31:0] a;
      logic [31:0] b;
   } vec_t;

   exp_t sb[$];

   vec_t mul_v[6] = '{
      '{2'd0, 32'd7,        32'hFFFFFFFD},
      '{2'd1, 32'd5,        32'd1},
      '{2'd0, 32'h80000000, 32'h80000000},
      '{2'd0, 32'hFFFFFFFF, 32'd1},
      '{2'd1, 32'h12345678, 32'd0},
      '{2'd1, 32'hDEADBEEF, 32'h00010001}
   };

   vec_t div_v[6] = '{
      '{2'd2, 32'hFFFFFFF9, 32'd2},
      '{2'd2, 32'h80000000, 32'hFFFFFFFF},
      '{2'd3, 32'd7,        32'd2},
      '{2'd2, 32'd7,        32'hFFFFFFFE},
      '{2'd3, 32'hFFFFFFFF, 32'd1},
      '{2'd2, 32'hFFFFFF9C, 32'hFFFFFFF9}
   };

   mult_div_unit dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .rs_val   (rs_val),
      .rt_val   (rt_val),
      .hi_we    (hi_we),
      .lo_we    (lo_we),
      .wdata    (wdata),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic exp_t model(input logic [1:0] o,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  input logic [31:0] h,
                                  input logic [31:0] l);
      exp_t        e;
      logic [63:0] pr;
      longint      q;
      longint      r;
      logic [31:0] m;
      int          k;
      e.hi  = h;
      e.lo  = l;
      e.dz  = 1'b0;
      e.lat = 33;
      case (o)
         2'd0: begin
            pr = 64'(longint'($signed(a)) * longint'($signed(b)));
            e.hi = pr[63:32];
            e.lo = pr[31:0];
         end
         2'd1: begin
            pr = {32'd0, a} * {32'd0, b};
            e.hi = pr[63:32];
            e.lo = pr[31:0];
         end
         2'd2: begin
            if (b == 0) begin
               e.dz  = 1'b1;
               e.lat = 1;
            end else begin
               q = longint'($signed(a)) / longint'($signed(b));
               r = longint'($signed(a)) % longint'($signed(b));
               e.lo = q[31:0];
               e.hi = r[31:0];
            end
         end
         default: begin
            if (b == 0) begin
               e.dz  = 1'b1;
               e.lat = 1;
            end else begin
               e.lo = a / b;
               e.hi = a % b;
            end
         end
      endcase
`ifdef MULDIV_EARLY_OUT_EN
      if (!o[1]) begin
         m = (!o[0] && b[31]) ? -b : b;
         k = 0;
         for (int i = 0; i < 32; i++)
            if (m[i]) k = i;
         e.lat = k + 2;
      end
`endif
      return e;
   endfunction

   // Called at a negedge with the unit idle; returns after the start edge.
   task automatic drive_start(input logic [1:0] o,
                              input logic [31:0] a,
                              input logic [31:0] b,
                              input logic hwe,
                              input logic lwe,
                              input logic [31:0] wd);
      exp_t e;
      if (hwe) sh_hi = wd;
      if (lwe) sh_lo = wd;
      e = model(o, a, b, sh_hi, sh_lo);
      if (!e.dz) begin
         sh_hi = e.hi;
         sh_lo = e.lo;
      end
      sb.push_back(e);
      op     = o;
      rs_val = a;
      rt_val = b;
      hi_we  = hwe;
      lo_we  = lwe;
      wdata  = wd;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      hi_we  = 1'b0;
      lo_we  = 1'b0;
      op     = 2'($urandom_range(0, 3));
      rs_val = $urandom;
      rt_val = $urandom;
      t0     = cyc;
   endtask

   task automatic wait_done(output int lat);
      for (int i = 0; i < 100 && !done; i++) @(negedge clk);
      lat = done ? cyc - t0 : -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({busy, done, div_zero, hi, lo} !== 67'd0) begin
         bad++;
         $display("FAIL reset: busy=%b done=%b dz=%b hi=%h lo=%h, want all 0",
                  busy, done, div_zero, hi, lo);
      end
      rst = 1'b0;
      sh_hi = '0;
      sh_lo = '0;
   endtask

   task automatic test_mult();
      exp_t e;
      int   lat;
      foreach (mul_v[i]) begin
         drive_start(mul_v[i].o, mul_v[i].a, mul_v[i].b, 0, 0, 0);
         wait_done(lat);
         e = sb.pop_front();
         total++;
         if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz} || lat !== e.lat) begin
            bad++;
            $display("FAIL mult[%0d]: hi=%h lo=%h dz=%b lat=%0d, want hi=%h lo=%h dz=%b lat=%0d",
                     i, hi, lo, div_zero, lat, e.hi, e.lo, e.dz, e.lat);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   lat;
      drive_start(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
      for (int n = 0; n < 2; n++) begin
         wait_done(lat);
         e = sb.pop_front();
         total++;
         if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz} || lat !== e.lat) begin
            bad++;
            $display("FAIL b2b[%0d]: hi=%h lo=%h dz=%b lat=%0d, want hi=%h lo=%h dz=%b lat=%0d",
                     n, hi, lo, div_zero, lat, e.hi, e.lo, e.dz, e.lat);
         end
         if (n == 0) drive_start(2'd3, 32'd7, 32'd2, 0, 0, 0);
      end
   endtask

   task automatic test_div();
      exp_t e;
      int   lat;
      foreach (div_v[i]) begin
         drive_start(div_v[i].o, div_v[i].a, div_v[i].b, 0, 0, 0);
         wait_done(lat);
         e = sb.pop_front();
         total++;
         if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz} || lat !== e.lat) begin
            bad++;
            $display("FAIL div[%0d]: hi=%h lo=%h dz=%b lat=%0d, want hi=%h lo=%h dz=%b lat=%0d",
                     i, hi, lo, div_zero, lat, e.hi, e.lo, e.dz, e.lat);
         end
      end
   endtask

   task automatic test_div_zero();
      exp_t e;
      int   lat;
      hi_we = 1'b1;
      wdata = 32'h1234;
      @(negedge clk);
      hi_we = 1'b0;
      lo_we = 1'b1;
      wdata = 32'h5678;
      @(negedge clk);
      lo_we = 1'b0;
      sh_hi = 32'h1234;
      sh_lo = 32'h5678;
      total++;
      if ({hi, lo} !== {32'h1234, 32'h5678}) begin
         bad++;
         $display("FAIL mthi_mtlo: hi=%h lo=%h, want hi=00001234 lo=00005678",
                  hi, lo);
      end
      for (int n = 0; n < 2; n++) begin
         if (n == 0) drive_start(2'd3, 32'd9, 32'd0, 0, 0, 0);
         else        drive_start(2'd2, 32'd5, 32'd0, 1, 0, 32'hBEEF);
         wait_done(lat);
         e = sb.pop_front();
         total++;
         if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz} || lat !== e.lat) begin
            bad++;
            $display("FAIL divzero[%0d]: hi=%h lo=%h dz=%b lat=%0d, want hi=%h lo=%h dz=%b lat=%0d",
                     n, hi, lo, div_zero, lat, e.hi, e.lo, e.dz, e.lat);
         end
         @(negedge clk);
         total++;
         if ({done, div_zero} !== 2'b00) begin
            bad++;
            $display("FAIL pulse[%0d]: done=%b dz=%b one cycle later, want 0 0",
                     n, done, div_zero);
         end
      end
   endtask

   task automatic test_busy_ignore();
      exp_t e;
      int   lat;
      drive_start(2'd0, 32'h00012345, 32'h80000001, 0, 0, 0);
      repeat (4) @(negedge clk);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL busy_run: busy=%b, want 1", busy);
      end
      start  = 1'b1;
      op     = 2'd3;
      rs_val = 32'd1;
      rt_val = 32'd1;
      hi_we  = 1'b1;
      wdata  = 32'hAAAA;
      @(negedge clk);
      start  = 1'b0;
      hi_we  = 1'b0;
      wait_done(lat);
      e = sb.pop_front();
      total++;
      if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz} || lat !== e.lat) begin
         bad++;
         $display("FAIL busy_ignore: hi=%h lo=%h dz=%b lat=%0d, want hi=%h lo=%h dz=%b lat=%0d",
                  hi, lo, div_zero, lat, e.hi, e.lo, e.dz, e.lat);
      end
   endtask

   task automatic test_abort();
      logic seen;
      drive_start(2'd1, 32'h0F0F0F0F, 32'hF0000001, 0, 0, 0);
      void'(sb.pop_back());
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sh_hi = '0;
      sh_lo = '0;
      total++;
      if ({busy, done, div_zero, hi, lo} !== 67'd0) begin
         bad++;
         $display("FAIL abort_reset: busy=%b done=%b dz=%b hi=%h lo=%h, want all 0",
                  busy, done, div_zero, hi, lo);
      end
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seen |= done;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL abort_no_done: done seen=%b, want 0", seen);
      end
   endtask

   task automatic test_random();
      exp_t        e;
      int          lat;
      logic [1:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      for (int i = 0; i < 12; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
         if ($urandom_range(0, 7) == 0) b = '0;
         drive_start(o, a, b, 0, 0, 0);
         wait_done(lat);
         e = sb.pop_front();
         total++;
         if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz} || lat !== e.lat) begin
            bad++;
            $display("FAIL rand[%0d] op=%0d a=%h b=%h: hi=%h lo=%h dz=%b lat=%0d, want hi=%h lo=%h dz=%b lat=%0d",
                     i, o, a, b, hi, lo, div_zero, lat, e.hi, e.lo, e.dz, e.lat);
         end
      end
   endtask

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      op     = 2'd0;
      rs_val = '0;
      rt_val = '0;
      hi_we  = 1'b0;
      lo_we  = 1'b0;
      wdata  = '0;
      @(negedge clk);
      test_reset();
      test_mult();
      test_back_to_back();
      test_div();
      test_div_zero();
      test_busy_ignore();
      test_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit beside the ALU in the EX stage; owns the HI/LO register pair.
- Executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle.
- Supplies the hi/lo values that MFHI/MFLO forward into the ALU result path.
- Exposes busy/done so the hazard unit can stall MFHI/MFLO and new mul/div ops until results are ready.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_val  input  WIDTH  multiplicand / dividend.
- rt_val  input  WIDTH  multiplier / divisor.
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- div_zero  output  1  one-cycle pulse with done when the divisor was 0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (rst=1 at an edge): state IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; internal counter and operand registers cleared. Reset overrides everything, including mid-operation; the aborted operation produces no done.
- States: IDLE, RUN, FIX.
- IDLE, start=1 at edge E0:
  - Latch op and operand magnitudes: for signed ops take the absolute value and record the operand signs; for unsigned ops use operands as-is.
  - cnt<=0, busy<=1, state<=RUN.
- Zero divisor: if op is DIV/DIVU and rt_val==0, state<=FIX instead of RUN.
- RUN, one iteration per edge:
  - Multiply: shift-add, 64-bit product accumulator.
  - Divide: restoring, one quotient bit per cycle, 32-bit partial remainder.
  - At the edge where cnt==WIDTH-1, state<=FIX; cnt otherwise increments. RUN occupies edges E1..E32.
- FIX, edge E33 (E1 for a zero divisor):
  - Signed mult: negate the 64-bit product if the signs differ; hi<=product[63:32], lo<=product[31:0].
  - Divide: lo<=quotient, negated if the signs differ; hi<=remainder, carrying the dividend's sign.
  - Zero divisor: hi/lo unchanged; div_zero<=1.
  - In all cases: done<=1, busy<=0, state<=IDLE.
- done and div_zero are high only for the cycle after the FIX edge. Latency is 33 cycles from the start edge to hi/lo valid.
- Wrap rule: DIV 0x80000000 / -1 gives lo=0x80000000, hi=0 (natural two's-complement wrap, no trap).
- Back-to-back: start is accepted in the cycle done is high, because state is already IDLE.
- start while busy is ignored; no queueing.
- MTHI/MTLO:
  - In IDLE, hi_we/lo_we write wdata at the edge.
  - If start is also high at that edge, the write is applied and the operation starts; the result later overwrites HI/LO.
  - Writes while busy are ignored.
- Inputs rs_val/rt_val/op are don't-care except at the start edge.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: for MULT/MULTU, RUN exits to FIX at the first edge where the remaining unshifted multiplier bits are all zero. The product is still shifted into its correct position, so latency is variable, from 2 to 33 cycles. Divide is unaffected.
- Undefined: fixed 33-cycle latency for all non-zero-divisor ops.

Test Plan:
- MULT 7 x 0xFFFFFFFD (-3) -> done exactly 33 cycles after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Next, start issued in the done cycle with DIVU 7/2 -> lo=3, hi=1.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x1234, MTLO 0x5678, then DIVU 9/0 -> done and div_zero pulse 1 cycle after the start edge; hi=0x1234, lo=0x5678 unchanged.
- MULT in progress: at RUN cycle 5 pulse start (DIVU 1/1) and hi_we with wdata 0xAAAA -> both ignored; the original MULT result lands at cycle 33.
- rst asserted at RUN cycle 10 -> after that edge busy=0, done=0, hi=lo=0; no done pulse follows. With MULDIV_EARLY_OUT_EN, MULTU 5 x 1 -> done 2 cycles after start, lo=5, hi=0.
